// File: rtl/comp_chunk_if.sv
// Handshake and verdict bundle between a chunk producer and comp_chunk_accum.
interface comp_chunk_if;
    logic start;
    logic chunk_valid;
    logic g_in;
    logic l_in;
    logic e_in;
    logic busy;
    logic done;
    logic gt;
    logic lt;
    logic eq;
    logic err;

    modport master (
        output start, chunk_valid, g_in, l_in, e_in,
        input  busy, done, gt, lt, eq, err
    );

    modport slave (
        input  start, chunk_valid, g_in, l_in, e_in,
        output busy, done, gt, lt, eq, err
    );
endinterface

// File: rtl/comp_chunk_accum.sv
// Folds MSB-first 2-bit G/L/E chunk results into one registered verdict
// for a 2*NCHUNK-bit word, so one small comparator can be time-shared.
module comp_chunk_accum #(
    parameter int NCHUNK = 4
) (
    input logic         clk,
    input logic         rst,
    comp_chunk_if.slave bus
);
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    typedef enum logic [1:0] {V_EQ, V_GT, V_LT} verdict_t;

    state_t   state, state_nxt;
    verdict_t verdict, verdict_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic decided, decided_nxt;
    logic err_acc, err_acc_nxt;
    logic load_out, clear_out;
    logic onehot;
    logic busy_q, done_q, gt_q, lt_q, eq_q, err_q;

    assign onehot = ({bus.g_in, bus.l_in, bus.e_in} == 3'b100) ||
                    ({bus.g_in, bus.l_in, bus.e_in} == 3'b010) ||
                    ({bus.g_in, bus.l_in, bus.e_in} == 3'b001);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        decided_nxt = decided;
        verdict_nxt = verdict;
        err_acc_nxt = err_acc;
        load_out    = 1'b0;
        clear_out   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = ACCUM;
                    cnt_nxt     = '0;
                    decided_nxt = 1'b0;
                    verdict_nxt = V_EQ;
                    err_acc_nxt = 1'b0;
                    clear_out   = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.chunk_valid) begin
                    // A malformed chunk only poisons err; the first clean G/L decides.
                    if (!onehot) begin
                        err_acc_nxt = 1'b1;
                    end else if (!decided) begin
                        if (bus.g_in) begin
                            verdict_nxt = V_GT;
                            decided_nxt = 1'b1;
                        end else if (bus.l_in) begin
                            verdict_nxt = V_LT;
                            decided_nxt = 1'b1;
                        end
                    end
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == LAST) begin
                        state_nxt = DONE;
                        load_out  = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            decided <= 1'b0;
            verdict <= V_EQ;
            err_acc <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            decided <= decided_nxt;
            verdict <= verdict_nxt;
            err_acc <= err_acc_nxt;
            busy_q  <= (state_nxt == ACCUM);
            done_q  <= (state_nxt == DONE);
            if (clear_out) begin
                gt_q  <= 1'b0;
                lt_q  <= 1'b0;
                eq_q  <= 1'b0;
                err_q <= 1'b0;
            end else if (load_out) begin
                gt_q  <= !err_acc_nxt && (verdict_nxt == V_GT);
                lt_q  <= !err_acc_nxt && (verdict_nxt == V_LT);
                eq_q  <= !err_acc_nxt && (verdict_nxt == V_EQ);
                err_q <= err_acc_nxt;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_comp_chunk_accum.sv
// Directed bench for comp_chunk_accum (NCHUNK=4); outputs observed as {busy,done,gt,lt,eq,err}.
module tb_comp_chunk_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    localparam logic [2:0] E = 3'b001;
    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] L = 3'b010;
    localparam logic [2:0] Z = 3'b000;

    comp_chunk_if bus ();

    comp_chunk_accum #(.NCHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err};
    endfunction

    // Apply inputs for one cycle; on return outputs reflect the edge that sampled them.
    task automatic drive(input logic s, input logic v, input logic [2:0] gle);
        bus.start       = s;
        bus.chunk_valid = v;
        {bus.g_in, bus.l_in, bus.e_in} = gle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, Z);
        drive(1'b1, 1'b1, G);
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=000000", obs());
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, Z);
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=000000", obs());
        end
    endtask

    task automatic test_first_wins();
        drive(1'b1, 1'b0, Z);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL fw_start got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, G);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL fw_chunk3_busy got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, L);
        checks++;
        if (obs() !== 6'b011000) begin
            failures++;
            $display("FAIL fw_done_gt got=%b exp=011000", obs());
        end
        drive(1'b0, 1'b0, Z);
        checks++;
        if (obs() !== 6'b001000) begin
            failures++;
            $display("FAIL fw_hold got=%b exp=001000", obs());
        end
    endtask

    task automatic test_stall_eq();
        drive(1'b1, 1'b0, Z);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b0, G);
        drive(1'b0, 1'b0, L);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL stall_no_early_done got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b010010) begin
            failures++;
            $display("FAIL stall_done_eq got=%b exp=010010", obs());
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, Z);
            checks++;
            if (obs() !== 6'b000010) begin
                failures++;
                $display("FAIL stall_hold%0d got=%b exp=000010", i, obs());
            end
        end
    endtask

    task automatic test_lt_then_clear();
        drive(1'b1, 1'b0, Z);
        drive(1'b0, 1'b1, L);
        drive(1'b0, 1'b1, G);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b010100) begin
            failures++;
            $display("FAIL lt_done got=%b exp=010100", obs());
        end
        drive(1'b0, 1'b0, Z);
        drive(1'b1, 1'b0, Z);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL lt_cleared_on_start got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL lt_still_cleared got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, G);
        checks++;
        if (obs() !== 6'b011000) begin
            failures++;
            $display("FAIL lt_next_done_gt got=%b exp=011000", obs());
        end
        drive(1'b0, 1'b0, Z);
    endtask

    task automatic test_err();
        drive(1'b1, 1'b0, Z);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, Z);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b010001) begin
            failures++;
            $display("FAIL err_done got=%b exp=010001", obs());
        end
        drive(1'b0, 1'b0, Z);
        checks++;
        if (obs() !== 6'b000001) begin
            failures++;
            $display("FAIL err_hold got=%b exp=000001", obs());
        end
        drive(1'b1, 1'b0, Z);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL err_cleared got=%b exp=100000", obs());
        end
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b010010) begin
            failures++;
            $display("FAIL err_clean_eq got=%b exp=010010", obs());
        end
        drive(1'b0, 1'b0, Z);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, Z);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, G);
        rst = 1'b1;
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL rstmid_cleared got=%b exp=000000", obs());
        end
        rst = 1'b0;
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL rstmid_no_done got=%b exp=000000", obs());
        end
        drive(1'b1, 1'b0, Z);
        drive(1'b0, 1'b1, L);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        drive(1'b0, 1'b1, E);
        checks++;
        if (obs() !== 6'b010100) begin
            failures++;
            $display("FAIL rstmid_fresh_lt got=%b exp=010100", obs());
        end
        drive(1'b0, 1'b0, Z);
    endtask

    task automatic test_start_ignored();
        // Chunk alongside the accepted start must be dropped; start in ACCUM/DONE must not restart.
        drive(1'b1, 1'b1, G);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL si_start got=%b exp=100000", obs());
        end
        drive(1'b1, 1'b1, E);
        drive(1'b1, 1'b1, E);
        drive(1'b0, 1'b1, L);
        checks++;
        if (obs() !== 6'b100000) begin
            failures++;
            $display("FAIL si_count3 got=%b exp=100000", obs());
        end
        drive(1'b1, 1'b1, E);
        checks++;
        if (obs() !== 6'b010100) begin
            failures++;
            $display("FAIL si_done_lt got=%b exp=010100", obs());
        end
        drive(1'b1, 1'b0, Z);
        checks++;
        if (obs() !== 6'b000100) begin
            failures++;
            $display("FAIL si_start_in_done got=%b exp=000100", obs());
        end
        drive(1'b0, 1'b0, Z);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.chunk_valid = 1'b0;
        bus.g_in        = 1'b0;
        bus.l_in        = 1'b0;
        bus.e_in        = 1'b0;
        test_reset();
        test_first_wins();
        test_stall_eq();
        test_lt_then_clear();
        test_err();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
